// File: rtl/xalu_multi_if.sv
// rtl/xalu_multi_if.sv - op/operand/result bundle between the E stage and xalu_multi
interface xalu_multi_if #(
  parameter int WIDTH = 32
);
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic [WIDTH-1:0] out;
  logic             err;

  modport master (output op, output a, output b, input busy, input out, input err);
  modport slave  (input op, input a, input b, output busy, output out, output err);
endinterface

// File: rtl/xalu_multi.sv
// rtl/xalu_multi.sv - multi-cycle multiply/divide unit with HI/LO registers
// Define XALU_MADD_EN to enable the madd/maddu/msub/msubu accumulate ops (9..12).
module xalu_multi #(
  parameter int WIDTH    = 32,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic         clk,
  input  logic         reset,
  xalu_multi_if.slave  bus
);
  localparam int W2 = 2 * WIDTH;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;
`ifdef XALU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
  localparam logic [3:0] OP_MSUB  = 4'd11;
  localparam logic [3:0] OP_MSUBU = 4'd12;
`endif

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [WIDTH-1:0] hi, lo;
  logic [WIDTH-1:0] res_hi, res_lo;
  logic [7:0]       cnt;
  logic             busy_q, err_q;

  logic             start_op, legal_op;
  logic [WIDTH-1:0] nxt_hi, nxt_lo;
  logic [7:0]       nxt_lat;

  always_comb begin
    start_op = 1'b0;
    legal_op = 1'b0;
    case (bus.op)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
        start_op = 1'b1;
        legal_op = 1'b1;
      end
      OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO: legal_op = 1'b1;
`ifdef XALU_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
        start_op = 1'b1;
        legal_op = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  logic signed [W2-1:0] prod_s;
  logic        [W2-1:0] prod_u;

  assign prod_s = $signed({{WIDTH{bus.a[WIDTH-1]}}, bus.a}) * $signed({{WIDTH{bus.b[WIDTH-1]}}, bus.b});
  assign prod_u = {{WIDTH{1'b0}}, bus.a} * {{WIDTH{1'b0}}, bus.b};

  // Divisors are forced to 1 in the special cases so the dividers never see /0 or overflow;
  // the real special-case results are muxed in below.
  logic                    div_zero, div_ovf;
  logic        [WIDTH-1:0] divisor_s, divisor_u;
  logic signed [WIDTH-1:0] q_s, r_s;
  logic        [WIDTH-1:0] q_u, r_u;

  assign div_zero  = (bus.b == '0);
  assign div_ovf   = (bus.a == MOST_NEG) && (bus.b == '1);
  assign divisor_s = (div_zero || div_ovf) ? ONE : bus.b;
  assign divisor_u = div_zero ? ONE : bus.b;
  assign q_s       = $signed(bus.a) / $signed(divisor_s);
  assign r_s       = $signed(bus.a) % $signed(divisor_s);
  assign q_u       = bus.a / divisor_u;
  assign r_u       = bus.a % divisor_u;

`ifdef XALU_MADD_EN
  logic [W2-1:0] hilo, acc_madd, acc_maddu, acc_msub, acc_msubu;

  assign hilo      = {hi, lo};
  assign acc_madd  = hilo + $unsigned(prod_s);
  assign acc_maddu = hilo + prod_u;
  assign acc_msub  = hilo - $unsigned(prod_s);
  assign acc_msubu = hilo - prod_u;
`endif

  always_comb begin
    nxt_hi  = '0;
    nxt_lo  = '0;
    nxt_lat = 8'(MULT_LAT);
    case (bus.op)
      OP_MULT:  {nxt_hi, nxt_lo} = $unsigned(prod_s);
      OP_MULTU: {nxt_hi, nxt_lo} = prod_u;
      OP_DIV: begin
        nxt_lat = 8'(DIV_LAT);
        if (div_zero) begin
          nxt_hi = bus.a;
          nxt_lo = '1;
        end else if (div_ovf) begin
          nxt_hi = '0;
          nxt_lo = bus.a;
        end else begin
          nxt_hi = $unsigned(r_s);
          nxt_lo = $unsigned(q_s);
        end
      end
      OP_DIVU: begin
        nxt_lat = 8'(DIV_LAT);
        if (div_zero) begin
          nxt_hi = bus.a;
          nxt_lo = '1;
        end else begin
          nxt_hi = r_u;
          nxt_lo = q_u;
        end
      end
`ifdef XALU_MADD_EN
      OP_MADD:  {nxt_hi, nxt_lo} = acc_madd;
      OP_MADDU: {nxt_hi, nxt_lo} = acc_maddu;
      OP_MSUB:  {nxt_hi, nxt_lo} = acc_msub;
      OP_MSUBU: {nxt_hi, nxt_lo} = acc_msubu;
`endif
      default: ;
    endcase
  end

  // The result is computed at the start edge and parked in res_*; HI/LO stay architectural
  // until the final countdown edge so mfhi/mflo keep returning pre-operation values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      hi     <= '0;
      lo     <= '0;
      res_hi <= '0;
      res_lo <= '0;
      cnt    <= '0;
      busy_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start_op) begin
            res_hi <= nxt_hi;
            res_lo <= nxt_lo;
            cnt    <= nxt_lat;
            busy_q <= 1'b1;
            state  <= RUN;
          end else if (bus.op == OP_MTHI) begin
            hi <= bus.a;
          end else if (bus.op == OP_MTLO) begin
            lo <= bus.a;
          end
        end
        RUN: begin
          err_q <= legal_op;
          cnt   <= cnt - 8'd1;
          if (cnt == 8'd1) begin
            hi     <= res_hi;
            lo     <= res_lo;
            busy_q <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.err  = err_q;
  assign bus.out  = (bus.op == OP_MFHI) ? hi :
                    (bus.op == OP_MFLO) ? lo : '0;
endmodule

// File: doc/xalu_multi.md
# xalu_multi

Parametrised multi-cycle multiply/divide unit with HI/LO registers, sitting in the E stage beside the ALU. It generalises the fixed-latency XALU:
- operand width, multiply latency and divide latency are parameters;
- multiply/divide behaviour is fully defined, including divide-by-zero and signed overflow;
- the `busy` output feeds the pause unit. The pause unit stalls D while `busy || op != 0` for any op in 1..12.

## Interface
- `WIDTH`, 32, operand width and HI/LO register width.
- `MULT_LAT`, 5, cycles `busy` stays high for mult/multu (and MAC ops). Legal range 1..255.
- `DIV_LAT`, 10, cycles `busy` stays high for div/divu. Legal range 1..255.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `op` input 4: operation code, sampled every cycle.
  - 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo.
  - 9 madd, 10 maddu, 11 msub, 12 msubu (only with the macro).
  - 13..15 are treated as none.
- `a` input WIDTH: rs operand, already forwarded.
- `b` input WIDTH: rt operand, already forwarded.
- `busy` output 1: a multi-cycle operation is in flight.
- `out` output WIDTH: HI when `op==5`, LO when `op==6`, else 0. Combinational from the registered HI/LO.
- `err` output 1: registered one-cycle pulse when an op in 1..12 arrives while `busy`.

## Operation
- FSM states:
  - IDLE to RUN on a start op (1..4, 9..12). On that edge, latch the computed result into `res_hi`/`res_lo`, load `cnt` with MULT_LAT or DIV_LAT, and set `busy`.
  - RUN: `cnt` decrements each cycle. At the edge where `cnt==1`, HI/LO take `res_hi`/`res_lo`, `busy` clears, and the FSM returns to IDLE.
- Arithmetic:
  - mult is signed and multu unsigned, each WIDTH×WIDTH to a 2·WIDTH product. HI gets the upper half, LO the lower half.
  - div/divu: LO gets the quotient and HI the remainder, truncating toward zero. The remainder takes the sign of the dividend.
  - Divide by zero: LO = all ones, HI = `a`. No exception is raised.
  - Signed overflow (most-negative / −1): LO = `a`, HI = 0.
- mthi/mtlo:
  - In IDLE, write `a` to HI or LO at the next edge, with no busy.
  - While `busy`, they are ignored and `err` pulses.
- mfhi/mflo are combinational reads of the architectural HI/LO. While busy they return the pre-operation values; pause prevents issue in that window.
- A start op while `busy` is ignored: the in-flight operation is unaffected and `err` pulses the next cycle.
- Operands are captured only on the start edge. Later changes on `a`/`b` have no effect.

## Timing
- Reset values: HI=0, LO=0, `busy`=0, `cnt`=0, `err`=0, FSM=IDLE. `out` therefore reads 0.
- Reset mid-operation: the result is discarded, HI/LO are zeroed, and `busy` is 0 the cycle after the reset edge.
- Start at edge E0:
  - `busy`=1 for cycles E0+1 .. E0+LAT.
  - HI/LO update at edge E0+LAT.
  - `busy`=0 and the new values are readable from cycle E0+LAT+1.
- With LAT=1, `busy` is high for exactly one cycle.
- A start op may be accepted in the same cycle `busy` falls. Back-to-back operations are therefore separated by 0 idle cycles after completion.
- mthi/mtlo latency is 1 cycle: the written value is readable via mfhi/mflo the next cycle.
- `err` is registered and high for exactly one cycle per offending op.

## Configuration
- `XALU_MADD_EN` defined:
  - ops 9..12 are legal and use MULT_LAT.
  - madd/maddu: {HI,LO} + product, computed with the HI/LO values present at the start edge.
  - msub/msubu: {HI,LO} − product, computed the same way.
  - signed ops use a signed product; u-variants use an unsigned product. Wrap modulo 2^(2·WIDTH).
- `XALU_MADD_EN` undefined: ops 9..12 behave as none, with no busy, no HI/LO change and no `err`. The accumulate adder is not synthesised.

## Test plan
- Reset, then mfhi and mflo → `out`=0 on both. Then multu a=0xFFFFFFFF, b=2 → `busy` high 5 cycles, then HI=0x00000001, LO=0xFFFFFFFE.
- mult a=−3, b=7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB after exactly MULT_LAT busy cycles. Checked with MULT_LAT=1 and MULT_LAT=5.
- Division:
  - div a=−7, b=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - div a=0x80000000, b=−1 → LO=0x80000000, HI=0.
  - divu a=5, b=0 → LO=0xFFFFFFFF, HI=5.
- During div busy:
  - issue mult and mthi → both ignored, `err` pulses twice, div result intact.
  - mfhi in the same window → returns the old HI.
- Start div, assert reset at busy cycle 4 → next cycle `busy`=0, HI=LO=0, and no later update occurs.
- With XALU_MADD_EN: mtlo 10, mthi 0, then madd a=3, b=4 → LO=22, HI=0. Then msubu a=1, b=23 → HI=0xFFFFFFFF, LO=0xFFFFFFFF. Without the macro, the same sequence leaves HI=0, LO=10 and `busy` never rises.
